// File: rtl/bcd_xs3_seq.sv
// bcd_xs3_seq
// Multi-digit BCD <-> Excess-3 conversion sequencer. A packed word of
// DIGITS 4-bit digits is latched on a start request and pushed, least
// significant digit first, through a single shared digit converter at one
// digit per clock. Invalid source codes are flagged per digit.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - conversion request, sampled while idle
//   dir      - 0: BCD->XS3, 1: XS3->BCD (sampled with start)
//   a        - packed source word, digit k = a[4k+3:4k] (sampled with start)
//   c        - packed result word (registered)
//   busy     - high during CONV and DONE
//   done     - one-cycle completion pulse
//   err      - OR of err_mask
//   err_mask - bit k set when source digit k was an invalid code
module bcd_xs3_seq #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [4*DIGITS-1:0]   a,
  output logic [4*DIGITS-1:0]   c,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DIGITS-1:0]     err_mask
);

  localparam int                W        = 4 * DIGITS;
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0]   IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [IDXW-1:0]   idx_r;
  logic [W-1:0]      src_r;
  logic              dir_r;

  logic [4:0]        conv_s;
  logic [W-1:0]      c_next_s;
  logic [DIGITS-1:0] mask_next_s;

  // Digit converter: returns {invalid_flag, converted_digit}. Invalid codes
  // produce a zero digit so c never carries an undefined value.
  function automatic logic [4:0] conv_digit(input logic [3:0] d, input logic to_bcd);
    logic [4:0] r;
    if (!to_bcd) begin
      if (d <= 4'd9) r = {1'b0, d + 4'd3};
      else           r = {1'b1, 4'b0000};
    end else begin
      if ((d >= 4'd3) && (d <= 4'd12)) r = {1'b0, d - 4'd3};
      else                             r = {1'b1, 4'b0000};
    end
    return r;
  endfunction

  // Shared converter works on the bottom digit of the source shift register
  always_comb begin
    conv_s = conv_digit(src_r[3:0], dir_r);
  end

  // Merge the current converted digit and its flag into result/mask images
  always_comb begin
    c_next_s    = c;
    mask_next_s = err_mask;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_r == IDXW'(k)) begin
        c_next_s[4*k +: 4] = conv_s[3:0];
        mask_next_s[k]     = conv_s[4];
      end else begin
        c_next_s[4*k +: 4] = c[4*k +: 4];
        mask_next_s[k]     = err_mask[k];
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      src_r    <= '0;
      dir_r    <= 1'b0;
      c        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_r    <= a;
            dir_r    <= dir;
            c        <= '0;
            err_mask <= '0;
            err      <= 1'b0;
            idx_r    <= '0;
            busy     <= 1'b1;
            state_r  <= CONV;
          end else begin
            busy <= 1'b0;
          end
        end
        CONV: begin
          c        <= c_next_s;
          err_mask <= mask_next_s;
          err      <= |mask_next_s;
          // Shift so the next digit lands in the converter's input slot
          src_r    <= src_r >> 3'd4;
          idx_r    <= idx_r + IDX_ONE;
          if (idx_r == LAST_IDX) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            done <= 1'b0;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Self-checking bench for bcd_xs3_seq (DIGITS=4): directed and random words
// compared against an arithmetic reference model of the digit code rules.
module tb_bcd_xs3_seq;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic          clk;
  logic          rst;
  logic          start;
  logic          dir;
  logic [W-1:0]  a;
  logic [W-1:0]  c;
  logic          busy;
  logic          done;
  logic          err;
  logic [D-1:0]  err_mask;

  int n_cmp;
  int n_err;

  bcd_xs3_seq #(.DIGITS(D), .IDXW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .a        (a),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each digit treated as a number 0..15 and mapped by the rules
  task automatic model(input logic [W-1:0] word, input logic d, output logic [W-1:0] res, output logic [D-1:0] mask);
    int v;
    int o;
    res  = '0;
    mask = '0;
    for (int k = 0; k < D; k++) begin
      v = (int'(word) >> (4 * k)) % 16;
      if (d == 1'b0) begin
        if (v < 10) o = v + 3;
        else begin o = 0; mask[k] = 1'b1; end
      end else begin
        if (v >= 3 && v <= 12) o = v - 3;
        else begin o = 0; mask[k] = 1'b1; end
      end
      res = res | (W'(o) << (4 * k));
    end
  endtask

  task automatic run_word(input logic [W-1:0] aw, input logic dw, input string tag);
    logic [W-1:0] ec;
    logic [D-1:0] em;
    int cnt;
    int bcnt;
    model(aw, dw, ec, em);
    @(negedge clk);
    a = aw; dir = dw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    dir = 1'($urandom);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    cnt = 0;
    bcnt = 1;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (busy) bcnt++;
    end
    check({tag, "_lat"}, 32'(cnt), 32'(D));
    check({tag, "_c"}, 32'(c), 32'(ec));
    check({tag, "_mask"}, 32'(err_mask), 32'(em));
    check({tag, "_err"}, 32'(err), 32'(|em));
    check({tag, "_busyn"}, 32'(bcnt), 32'(D + 1));
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ec;
    logic [D-1:0] em;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] hold_c;
    int cnt;
    bit saw_done;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; dir = 1'b0; a = '0;
    #13;
    check("rst_c", 32'(c), 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check("rst_mask", 32'(err_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_word(16'h1234, 1'b0, "b2x_1234");
    check("c_4567", 32'(c), 32'h4567);
    run_word(16'h9A05, 1'b0, "b2x_9A05");
    check("c_C038", 32'(c), 32'hC038);
    check("mask_0100", 32'(err_mask), 32'h4);
    run_word(16'h4567, 1'b1, "x2b_4567");
    check("c_1234", 32'(c), 32'h1234);
    run_word(16'h2D33, 1'b1, "x2b_2D33");
    check("c_0000", 32'(c), 32'h0);
    check("mask_1100", 32'(err_mask), 32'hC);

    // every single-digit code in position 0, both directions
    for (int code = 0; code < 16; code++) begin
      for (int dd = 0; dd < 2; dd++) begin
        run_word({12'($urandom), 4'(code)}, 1'(dd), "sweep");
      end
    end

    for (int r = 0; r < 30; r++) begin
      run_word(W'($urandom), 1'($urandom), "rand");
    end

    // start held high: back-to-back words, a changed before the second latch
    a0 = 16'h0581;
    a1 = 16'h7236;
    @(negedge clk);
    a = a0; dir = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) a = a1;
      check("held_done", 32'(done), 32'((i == 4) || (i == 10) || (i == 16)));
      if (done) begin
        model((i == 4) ? a0 : a1, 1'b0, ec, em);
        check("held_c", 32'(c), 32'(ec));
      end
    end
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("held_tail_done", 32'(done), 32'd1);
    model(a1, 1'b0, ec, em);
    check("held_tail_c", 32'(c), 32'(ec));
    hold_c = c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = W'($urandom);
      dir = 1'($urandom);
    end
    check("idle_hold_c", 32'(c), 32'(hold_c));
    check("idle_busy", 32'(busy), 32'd0);

    // asynchronous reset while digit index is 2
    @(negedge clk);
    a = 16'h5678; dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_flags", {30'd0, busy, done}, 32'd0);
    check("arst_c", 32'(c), 32'd0);
    check("arst_mask", 32'(err_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_word(16'h0009, 1'b0, "after_rst");
    check("c_333C", 32'(c), 32'h333C);

    // start and reset together: reset wins, no conversion follows
    @(negedge clk);
    a = 16'h1234; dir = 1'b0; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("sim_busy", 32'(busy), 32'd0);
    start = 1'b0;
    #1 rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("sim_no_done", 32'(saw_done), 32'd0);
    check("sim_c", 32'(c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
